// File: rtl/memoredf_pkg.sv
// Shared definitions for the MemGuard dispatcher slice.
// - dispatch_state_t : dispatcher FSM encoding (IDLE, SEND, NOTIFY).
// - idx_width()      : width of a queue index, never below 1 bit.
// - QUEUE_IDX_W      : index width for the default 4-queue build.
// - sat_inc()        : saturating increment of a counter of a given width.
package memoredf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    NOTIFY = 2'd2
  } dispatch_state_t;

  // A single queue still needs a 1-bit index port.
  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  localparam int unsigned DEFAULT_NUM_QUEUES = 4;
  localparam int unsigned QUEUE_IDX_W        = idx_width(DEFAULT_NUM_QUEUES);

  // Counters up to 32 bits wide; caller slices the result back to its width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? max_v : (value + 32'd1);
  endfunction

endpackage

// File: rtl/memguard_served_counters.sv
// Per-queue saturating "served" counter bank for the MemGuard dispatcher.
// Only compiled when MEMGUARD_DISPATCH_STATS_EN is defined; the default build
// contains no counter logic at all.
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   synchronous active-low reset, zeroes all counters
//   inc_i    increment the counter selected by idx_i
//   idx_i    queue index to increment
//   clear_i  zero all counters next cycle; wins over a simultaneous increment
//   count_o  packed per-queue counter values
`ifdef MEMGUARD_DISPATCH_STATS_EN
module memguard_served_counters
  import memoredf_pkg::*;
#(
  parameter int unsigned NumQueues  = 4,
  parameter int unsigned CountWidth = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  inc_i,
  input  logic [idx_width(NumQueues)-1:0]       idx_i,
  input  logic                                  clear_i,
  output logic [NumQueues-1:0][CountWidth-1:0]  count_o
);

  logic [NumQueues-1:0][CountWidth-1:0] cnt_q, cnt_d;
  logic [31:0]                          inc_val;

  always_comb begin
    cnt_d   = cnt_q;
    inc_val = '0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      for (int unsigned i = 0; i < NumQueues; i++) begin
        if (32'(idx_i) == i) begin
          inc_val  = sat_inc(32'(cnt_q[i]), CountWidth);
          cnt_d[i] = inc_val[CountWidth-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule
`endif

// File: rtl/memguard_dispatcher.sv
// MemGuard dispatcher: consumer end of the scheduling interface. Pops the head
// of the queue chosen by the scheduler, forwards it on a valid/ready master
// port and returns a one-cycle update pulse once the master accepts it.
// Optional served statistics are built only with MEMGUARD_DISPATCH_STATS_EN.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   valid, selection    scheduler request and chosen queue index
//   empty, queue_data   per-queue empty flags and FWFT head entries
//   pop                 one-hot dequeue strobe (combinational, IDLE only)
//   m_valid/m_data/m_source/m_ready  master port
//   update              one-cycle "served" pulse back to the scheduler
//   served_count        per-queue served totals (0 without the stats macro)
//   served_clear        zero served_count (ignored without the stats macro)
module memguard_dispatcher
  import memoredf_pkg::*;
#(
  parameter int unsigned NUMBER_OF_QUEUES = 4,
  parameter int unsigned DATA_WIDTH       = 64,
  parameter int unsigned REGISTER_SIZE    = 4
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           valid,
  input  logic [idx_width(NUMBER_OF_QUEUES)-1:0]         selection,
  input  logic [NUMBER_OF_QUEUES-1:0]                    empty,
  input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0]    queue_data,
  output logic [NUMBER_OF_QUEUES-1:0]                    pop,
  output logic                                           m_valid,
  output logic [DATA_WIDTH-1:0]                          m_data,
  output logic [idx_width(NUMBER_OF_QUEUES)-1:0]         m_source,
  input  logic                                           m_ready,
  output logic                                           update,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] served_count,
  input  logic                                           served_clear
);

  localparam int unsigned SelW = idx_width(NUMBER_OF_QUEUES);

  dispatch_state_t       state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SelW-1:0]       source_q, source_d;
  logic                  sel_ok;
  logic                  can_pop;

  always_comb begin
    // Out-of-range selections only exist for non-power-of-2 queue counts.
    sel_ok  = (32'(selection) < NUMBER_OF_QUEUES);
    // Gated by reset so pop stays low while the block is held in reset.
    can_pop = reset && (state_q == IDLE) && valid && sel_ok && !empty[selection];

    pop = '0;
    if (can_pop) begin
      pop[selection] = 1'b1;
    end

    state_d  = state_q;
    data_d   = data_q;
    source_d = source_q;
    unique case (state_q)
      IDLE: begin
        if (can_pop) begin
          data_d   = queue_data[selection];
          source_d = selection;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (m_ready) begin
          state_d = NOTIFY;
        end
      end
      NOTIFY:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      source_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      source_q <= source_d;
    end
  end

  // Decoded from registered state only; m_ready never reaches these.
  assign m_valid  = (state_q == SEND);
  assign update   = (state_q == NOTIFY);
  assign m_data   = data_q;
  assign m_source = source_q;

`ifdef MEMGUARD_DISPATCH_STATS_EN
  memguard_served_counters #(
    .NumQueues  (NUMBER_OF_QUEUES),
    .CountWidth (REGISTER_SIZE)
  ) u_served_counters (
    .clk_i   (clock),
    .rst_ni  (reset),
    .inc_i   (update),
    .idx_i   (source_q),
    .clear_i (served_clear),
    .count_o (served_count)
  );
`else
  logic unused_served_clear;
  assign unused_served_clear = served_clear;
  assign served_count        = '0;
`endif

endmodule

// File: tb/tb_memguard_dispatcher.sv
module tb_memguard_dispatcher;

  localparam int unsigned NQ = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned RS = 4;
  localparam int unsigned CMAX = (1 << RS) - 1;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   valid;
  logic [1:0]             selection;
  logic [NQ-1:0]          empty;
  logic [NQ-1:0][DW-1:0]  queue_data;
  logic [NQ-1:0]          pop;
  logic                   m_valid;
  logic [DW-1:0]          m_data;
  logic [1:0]             m_source;
  logic                   m_ready;
  logic                   update;
  logic [NQ-1:0][RS-1:0]  served_count;
  logic                   served_clear;

  memguard_dispatcher #(
    .NUMBER_OF_QUEUES (NQ),
    .DATA_WIDTH       (DW),
    .REGISTER_SIZE    (RS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .valid        (valid),
    .selection    (selection),
    .empty        (empty),
    .queue_data   (queue_data),
    .pop          (pop),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_source     (m_source),
    .m_ready      (m_ready),
    .update       (update),
    .served_count (served_count),
    .served_clear (served_clear)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a dispatcher holds at most one entry; it is offered
  // until accepted, then the scheduler is notified exactly once.
  bit          mdl_busy = 1'b0;  // an entry has been dequeued and not yet notified
  bit          mdl_acc  = 1'b0;  // master accepted it; notification is due now
  logic [63:0] mdl_data = '0;
  int unsigned mdl_src  = 0;
  int unsigned mdl_cnt [NQ];

  function automatic logic [NQ-1:0] exp_pop();
    logic [NQ-1:0] e;
    e = '0;
    if (reset && !mdl_busy && valid && (int'(selection) < NQ) && !empty[selection])
      e[selection] = 1'b1;
    return e;
  endfunction

  function automatic logic [15:0] exp_counts();
    logic [15:0] v;
    v = '0;
`ifdef MEMGUARD_DISPATCH_STATS_EN
    for (int i = 0; i < NQ; i++) v[i*RS +: RS] = mdl_cnt[i][RS-1:0];
`endif
    return v;
  endfunction

  always @(posedge clock) begin
    logic [NQ-1:0] p;
    p = exp_pop();
    if (!reset) begin
      mdl_busy = 1'b0;
      mdl_acc  = 1'b0;
      for (int i = 0; i < NQ; i++) mdl_cnt[i] = 0;
    end else begin
      if (mdl_acc) begin
        mdl_acc  = 1'b0;
        mdl_busy = 1'b0;
        if (mdl_cnt[mdl_src] < CMAX) mdl_cnt[mdl_src] = mdl_cnt[mdl_src] + 1;
      end else if (mdl_busy) begin
        if (m_ready) mdl_acc = 1'b1;
      end else if (p != '0) begin
        mdl_busy = 1'b1;
        mdl_data = queue_data[selection];
        mdl_src  = int'(selection);
      end
      if (served_clear) for (int i = 0; i < NQ; i++) mdl_cnt[i] = 0;
    end
  end

  always @(negedge clock) begin
    if (run) begin
      chk("pop", 64'(pop), 64'(exp_pop()));
      chk("m_valid", 64'(m_valid), 64'(mdl_busy && !mdl_acc));
      chk("update", 64'(update), 64'(mdl_acc));
      if (mdl_busy && !mdl_acc) begin
        chk("m_data", m_data, mdl_data);
        chk("m_source", 64'(m_source), 64'(mdl_src));
      end
      chk("served_count", 64'(served_count), 64'(exp_counts()));
    end
  end

  // Event monitors for sequence-level checks.
  int unsigned cyc_n = 0;
  int unsigned pop_total = 0;
  int unsigned upd_total = 0;
  int unsigned upd_cycles [$];
  int unsigned src_seq [$];

  always @(posedge clock) cyc_n++;

  always @(negedge clock) begin
    pop_total += $countones(pop);
    if (update) begin
      upd_total++;
      upd_cycles.push_back(cyc_n);
    end
    if (m_valid && m_ready) src_seq.push_back(int'(m_source));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned p0, u0;
    reset        = 1'b0;
    valid        = 1'b1;
    selection    = 2'd2;
    empty        = 4'b0000;
    m_ready      = 1'b1;
    served_clear = 1'b0;
    for (int i = 0; i < NQ; i++) queue_data[i] = 64'h1000 + 64'(i);
    queue_data[2] = 64'hAB;
    cyc(3);
    run = 1'b1;
    @(negedge clock);
    chk("rst_pop", 64'(pop), 64'h0);
    chk("rst_m_valid", 64'(m_valid), 64'h0);
    chk("rst_m_data", m_data, 64'h0);
    chk("rst_m_source", 64'(m_source), 64'h0);
    chk("rst_update", 64'(update), 64'h0);
    chk("rst_served", 64'(served_count), 64'h0);

    // 1: basic flow
    cyc(1);
    reset = 1'b1;
    @(negedge clock);
    chk("t1_pop", 64'(pop), 64'h4);
    cyc(1);
    valid = 1'b0;
    @(negedge clock);
    chk("t1_m_valid", 64'(m_valid), 64'h1);
    chk("t1_m_data", m_data, 64'hAB);
    chk("t1_m_source", 64'(m_source), 64'h2);
    chk("t1_pop_after", 64'(pop), 64'h0);
    cyc(1);
    @(negedge clock);
    chk("t1_update", 64'(update), 64'h1);
    cyc(1);
    @(negedge clock);
    chk("t1_update_low", 64'(update), 64'h0);
    chk("t1_idle", 64'(m_valid), 64'h0);

    // 2: backpressure, selection changes during SEND are ignored
    cyc(1);
    p0 = pop_total;
    u0 = upd_total;
    queue_data[1] = 64'h1234;
    valid = 1'b1;
    selection = 2'd1;
    m_ready = 1'b0;
    @(negedge clock);
    chk("t2_pop", 64'(pop), 64'h2);
    cyc(1);
    selection = 2'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t2_hold_valid", 64'(m_valid), 64'h1);
      chk("t2_hold_data", m_data, 64'h1234);
      cyc(1);
    end
    m_ready = 1'b1;
    valid = 1'b0;
    @(negedge clock);
    chk("t2_valid_6th", 64'(m_valid), 64'h1);
    cyc(1);
    m_ready = 1'b0;
    @(negedge clock);
    chk("t2_update", 64'(update), 64'h1);
    cyc(2);
    chk("t2_one_pop", 64'(pop_total - p0), 64'h1);
    chk("t2_one_update", 64'(upd_total - u0), 64'h1);

    // 3: empty race
    valid = 1'b1;
    selection = 2'd1;
    empty = 4'b0010;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t3_pop", 64'(pop), 64'h0);
      chk("t3_m_valid", 64'(m_valid), 64'h0);
      cyc(1);
    end
    valid = 1'b0;
    empty = 4'b0000;
    cyc(2);

    // 4: back-to-back, alternating 0 and 3
    upd_cycles.delete();
    src_seq.delete();
    valid = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      selection = (k % 2 == 1) ? 2'd3 : 2'd0;
      cyc(3);
    end
    valid = 1'b0;
    cyc(2);
    chk("t4_n_sources", 64'(src_seq.size()), 64'd4);
    chk("t4_n_updates", 64'(upd_cycles.size()), 64'd4);
    if (src_seq.size() == 4) begin
      chk("t4_src0", 64'(src_seq[0]), 64'd0);
      chk("t4_src1", 64'(src_seq[1]), 64'd3);
      chk("t4_src2", 64'(src_seq[2]), 64'd0);
      chk("t4_src3", 64'(src_seq[3]), 64'd3);
    end
    for (int i = 1; i < upd_cycles.size(); i++)
      chk("t4_update_gap", 64'(upd_cycles[i] - upd_cycles[i-1]), 64'd3);

    // 5: reset mid-SEND drops the entry without an update
    valid = 1'b1;
    selection = 2'd0;
    m_ready = 1'b0;
    @(negedge clock);
    chk("t5_pop", 64'(pop), 64'h1);
    cyc(1);
    valid = 1'b0;
    @(negedge clock);
    chk("t5_in_send", 64'(m_valid), 64'h1);
    u0 = upd_total;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    @(negedge clock);
    chk("t5_m_valid", 64'(m_valid), 64'h0);
    chk("t5_update", 64'(update), 64'h0);
    reset = 1'b1;
    m_ready = 1'b1;
    cyc(5);
    chk("t5_no_update", 64'(upd_total - u0), 64'h0);

    // 6: statistics saturation and clear (clear coincides with a NOTIFY)
    valid = 1'b1;
    selection = 2'd1;
    cyc(60);
    valid = 1'b0;
    cyc(3);
    @(negedge clock);
`ifdef MEMGUARD_DISPATCH_STATS_EN
    chk("t6_saturated", 64'(served_count[1]), 64'd15);
`else
    chk("t6_tied_zero", 64'(served_count), 64'h0);
`endif
    cyc(1);
    valid = 1'b1;
    selection = 2'd2;
    cyc(1);
    valid = 1'b0;
    cyc(1);
    @(negedge clock);
    chk("t6_notify", 64'(update), 64'h1);
    served_clear = 1'b1;
    cyc(1);
    served_clear = 1'b0;
    @(negedge clock);
    chk("t6_cleared", 64'(served_count), 64'h0);
    cyc(2);

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memguard_dispatcher.md
Name: memguard_dispatcher

Overview:
- Consumer end of the MemGuard scheduling interface.
- Takes the scheduler's valid/selection, pops the head entry of the selected first-word-fall-through queue and forwards it on a valid/ready master port.
- Once the master port accepts the entry, returns a one-cycle update pulse to the scheduler, which closes the regulation loop.
- Sits between the per-core request queues and the memory-side port.

Parameters:
- NUMBER_OF_QUEUES, 4, number of request queues and scheduler inputs.
- DATA_WIDTH, 64, width of one queued transaction word.
- REGISTER_SIZE, 4, width of each per-queue served counter; matches the scheduler budget width.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- valid  in  1  scheduler has an eligible queue.
- selection  in  $clog2(NUMBER_OF_QUEUES)  scheduler's chosen queue index.
- empty  in  NUMBER_OF_QUEUES  per-queue empty flags.
- queue_data  in  [NUMBER_OF_QUEUES][DATA_WIDTH]  head entry of each FWFT queue.
- pop  out  NUMBER_OF_QUEUES  one-hot dequeue strobe.
- m_valid  out  1  master-port transaction valid.
- m_data  out  DATA_WIDTH  master-port payload.
- m_source  out  $clog2(NUMBER_OF_QUEUES)  queue index of the payload.
- m_ready  in  1  master-port accept.
- update  out  1  one-cycle "transaction served" pulse to the scheduler.
- served_count  out  [NUMBER_OF_QUEUES][REGISTER_SIZE]  per-queue served totals (optional feature).
- served_clear  in  1  clears served_count (optional feature).

Behaviour:
- FSM states: IDLE, SEND, NOTIFY. Registered state, data and source.
- IDLE:
  - If valid and ~empty[selection]: pop[selection]=1 for this cycle only. Latch queue_data[selection] into m_data and selection into m_source. Next state SEND.
  - If valid and empty[selection] (race): no pop, stay IDLE.
- SEND:
  - m_valid=1; m_data and m_source are held stable.
  - m_ready=1 completes the handshake. Next state NOTIFY.
  - m_ready=0: remain in SEND indefinitely. valid and selection are ignored.
- NOTIFY:
  - update=1 for exactly one cycle. Next state IDLE unconditionally.
- Update spacing: update is never high on consecutive cycles; there are at least 2 low cycles between pulses, since the scheduler detects the falling edge.
- Timing:
  - Minimum latency from valid to m_valid: 1 cycle.
  - Minimum cycle count per served transaction: 3 cycles (IDLE, SEND, NOTIFY).
- pop is combinational from the IDLE state, valid, selection and empty; no other path drives it.
- m_valid and update are decoded only from registered state (no combinational path from m_ready).
- Reset values while reset=0: state IDLE, m_valid=0, m_data=0, m_source=0, update=0, pop=0, served_count=0.
- Reset asserted mid-SEND: the captured entry is dropped and no update is issued.
- selection values of NUMBER_OF_QUEUES or above (only possible for non-power-of-2 sizes) are treated as invalid: no pop, stay IDLE.

Optional Feature:
- Macro: MEMGUARD_DISPATCH_STATS_EN.
- Defined:
  - In NOTIFY, served_count[m_source] increments, saturating at all-ones.
  - served_clear=1 zeroes all counters next cycle and takes priority over a simultaneous increment.
- Undefined: served_count is tied to 0, served_clear is ignored, and no counter registers are built.

Decomposition:
- Shared package memoredf_pkg holds:
  - typedef dispatch_state_t {IDLE, SEND, NOTIFY};
  - QUEUE_IDX_W = $clog2(NUMBER_OF_QUEUES) helper;
  - the saturating-increment function.
- One sub-module is natural: memguard_served_counters, the per-queue saturating counter bank, instantiated only under MEMGUARD_DISPATCH_STATS_EN.

Test Plan:
1. Basic flow: reset released; valid=1, selection=2, empty=4'b0000, queue_data[2]=0xAB, m_ready=1.
   -> pop=4'b0100 for one cycle; next cycle m_valid=1, m_data=0xAB, m_source=2; next cycle update=1; then IDLE.
2. Backpressure: same stimulus with m_ready=0 for 5 cycles, then 1.
   -> m_valid stays high with m_data stable for 6 cycles; a single pop and a single update pulse; selection changes during SEND are ignored.
3. Empty race: valid=1, selection=1, empty=4'b0010.
   -> pop=0 and m_valid=0 for as long as the condition holds.
4. Back-to-back: valid held 1, alternating selections 0 and 3, m_ready=1.
   -> one transaction every 3 cycles; update pulses are separated by exactly 2 low cycles; m_source sequence is 0,3,0,3.
5. Reset mid-SEND: reset=0 while m_valid=1.
   -> next cycle m_valid=0, update=0, state IDLE; no update is ever issued for the dropped entry.
6. Stats (with MEMGUARD_DISPATCH_STATS_EN, REGISTER_SIZE=4): serve queue 1 twenty times.
   -> served_count[1]=15 (saturated); assert served_clear -> all counters read 0 next cycle.
